// File: rtl/button_pkg.sv
// button_pkg: shared event type, index-width helper and default timing for the button front end
package button_pkg;
    localparam int MAX_IDX_W        = 4;
    localparam int DEF_N_BTN        = 4;
    localparam int DEF_CLK_HZ       = 1_000_000;
    localparam int DEF_SAMPLE_HZ    = 1000;
    localparam int DEF_STABLE_CNT   = 3;
    localparam int DEF_LONG_SAMPLES = 1000;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] id;
        logic                 is_long;
    } btn_evt_t;

    function automatic int BTN_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: synchronise, debounce and time one button; flags each release with its press length
module btn_debounce_ch
    import button_pkg::*;
#(
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int LONG_SAMPLES = DEF_LONG_SAMPLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic rel_o,
    output logic long_o
);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int HW = $clog2(LONG_SAMPLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          level_q, level_d, differ, flip;

    always_comb begin
        differ  = sync_q[1] ^ level_q;
        flip    = tick_i && differ && cnt_q == CW'(STABLE_CNT - 1);
        cnt_d   = !tick_i ? cnt_q : (!differ || flip) ? '0 : cnt_q + 1'b1;
        level_d = level_q ^ flip;
        hold_d  = !tick_i                                    ? hold_q :
                  (flip && !level_q)                         ? '0 :
                  (level_q && hold_q != HW'(LONG_SAMPLES))   ? hold_q + 1'b1 : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
    assign rel_o   = flip && level_q;
    assign long_o  = hold_q >= HW'(LONG_SAMPLES);
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounced button front end with round-robin press-event arbitration
// onto a single valid/ready channel with sticky overrun reporting.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter int N_BTN        = DEF_N_BTN,
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int SAMPLE_HZ    = DEF_SAMPLE_HZ,
    parameter int STABLE_CNT   = DEF_STABLE_CNT,
    parameter int LONG_SAMPLES = DEF_LONG_SAMPLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_raw,
    input  logic                          evt_ready,
    input  logic                          ovr_clr,
    output logic                          evt_valid,
    output logic [BTN_IDX_W(N_BTN)-1:0]   evt_id,
    output logic                          evt_long,
    output logic [N_BTN-1:0]              btn_level,
    output logic                          overrun
);
    localparam int DIV = CLK_HZ / SAMPLE_HZ;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int IW  = BTN_IDX_W(N_BTN);

    logic [PW-1:0]    pre_q, pre_d;
    logic [N_BTN-1:0] rel, lng, pend_q, pend_d, plong_q, plong_d, drop, clr, keep;
    logic [IW-1:0]    rr_q, rr_d, gnt;
    logic             valid_q, valid_d, ovr_q, ovr_d, tick, found, load, take;
    btn_evt_t         out_q, out_d;

    assign tick = pre_q == PW'(DIV - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CNT  (STABLE_CNT),
            .LONG_SAMPLES(LONG_SAMPLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (btn_raw[i]),
            .tick_i (tick),
            .level_o(btn_level[i]),
            .rel_o  (rel[i]),
            .long_o (lng[i])
        );
    end

    always_comb begin
        found = 1'b0;
        gnt   = rr_q;
        for (int k = 1; k <= N_BTN; k++) begin
            if (!found && pend_q[(int'(rr_q) + k) % N_BTN]) begin
                found = 1'b1;
                gnt   = IW'((int'(rr_q) + k) % N_BTN);
            end
        end
        load    = !valid_q || evt_ready;
        take    = load && found;
        clr     = take ? N_BTN'(1) << gnt : '0;
        // a fresh release on the channel being granted this cycle is kept, not dropped
        drop    = rel & pend_q & ~clr;
        keep    = rel & ~drop;
        pend_d  = (pend_q & ~clr) | rel;
        plong_d = (plong_q & ~keep) | (lng & keep);
        ovr_d   = |drop || (ovr_q && !ovr_clr);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        valid_d = load ? found : valid_q;
        out_d   = take ? '{id: MAX_IDX_W'(gnt), is_long: plong_q[gnt]} : out_q;
        rr_d    = take ? gnt : rr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            pend_q  <= '0;
            plong_q <= '0;
            rr_q    <= IW'(N_BTN - 1);
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            pre_q   <= pre_d;
            pend_q  <= pend_d;
            plong_q <= plong_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            out_q   <= out_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_id    = IW'(out_q.id);
    assign evt_long  = out_q.is_long;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed, table-driven bench for the button event arbiter (DIV=4, STABLE=3, LONG=8)
module tb_button_event_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic       evt_ready, ovr_clr;
    logic       evt_valid, evt_long, overrun;
    logic [1:0] evt_id;
    logic [3:0] btn_level;
    int         cyc, checks, failures;

    typedef struct {
        int b;
        int n;
        bit ev;
        bit lg;
    } vec_t;
    vec_t vt[7];

    button_event_arbiter #(
        .N_BTN(4), .CLK_HZ(4000), .SAMPLE_HZ(1000), .STABLE_CNT(3), .LONG_SAMPLES(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .evt_ready(evt_ready),
        .ovr_clr  (ovr_clr),
        .evt_valid(evt_valid),
        .evt_id   (evt_id),
        .evt_long (evt_long),
        .btn_level(btn_level),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // advance to just after the next sampling edge (every 4th edge after reset release)
    task automatic to_tick();
        do step(); while (cyc % 4 != 0);
    endtask

    task automatic pulse(input logic [3:0] m, input int n);
        to_tick();
        btn_raw |= m;
        repeat (n) to_tick();
        btn_raw &= ~m;
        repeat (3) to_tick();
    endtask

    task automatic burst(input int first);
        pulse(4'hf, 4);
        evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("burst_valid", evt_valid, 1);
            chk("burst_id", evt_id, (first + k) % 4);
            chk("burst_long", evt_long, 0);
        end
        step();
        chk("burst_end", evt_valid, 0);
        evt_ready = 1'b0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        vt[0] = '{b: 1, n: 1,  ev: 0, lg: 0};
        vt[1] = '{b: 1, n: 2,  ev: 0, lg: 0};
        vt[2] = '{b: 2, n: 5,  ev: 1, lg: 0};
        vt[3] = '{b: 0, n: 12, ev: 1, lg: 1};
        vt[4] = '{b: 1, n: 3,  ev: 1, lg: 0};
        vt[5] = '{b: 3, n: 8,  ev: 1, lg: 0};
        vt[6] = '{b: 3, n: 9,  ev: 1, lg: 1};
        rst = 1'b1; btn_raw = '0; evt_ready = 1'b0; ovr_clr = 1'b0;
        step(); step();
        rst = 1'b0; cyc = 0;
        chk("rst_valid", evt_valid, 0);
        chk("rst_level", btn_level, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_id", evt_id, 0);

        for (int i = 0; i < 7; i++) begin
            to_tick();
            btn_raw[vt[i].b] = 1'b1;
            for (int t = 1; t <= vt[i].n; t++) begin
                to_tick();
                chk("level_press", btn_level, (t >= 3) ? (4'b1 << vt[i].b) : 4'b0);
            end
            btn_raw[vt[i].b] = 1'b0;
            for (int t = 1; t <= 3; t++) begin
                to_tick();
                chk("level_rel", btn_level, (vt[i].ev && t < 3) ? (4'b1 << vt[i].b) : 4'b0);
                chk("valid_early", evt_valid, 0);
            end
            step();
            chk("evt_valid", evt_valid, vt[i].ev);
            if (vt[i].ev) begin
                chk("evt_id", evt_id, vt[i].b);
                chk("evt_long", evt_long, vt[i].lg);
            end
            evt_ready = 1'b1;
            step();
            evt_ready = 1'b0;
            chk("valid_after_hs", evt_valid, 0);
        end

        burst(0);
        pulse(4'b0010, 3);
        step();
        chk("rr_prep_id", evt_id, 1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        burst(2);

        pulse(4'b1000, 3);
        step();
        chk("stall_valid", evt_valid, 1);
        chk("stall_id", evt_id, 3);
        chk("stall_long", evt_long, 0);
        pulse(4'b1000, 9);
        chk("stall_id2", evt_id, 3);
        chk("stall_long2", evt_long, 0);
        chk("stall_ovr0", overrun, 0);
        pulse(4'b1000, 3);
        chk("ovr_set", overrun, 1);
        chk("stall_id3", evt_id, 3);
        chk("stall_long3", evt_long, 0);
        chk("stall_valid3", evt_valid, 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        evt_ready = 1'b1;
        step();
        chk("queued_valid", evt_valid, 1);
        chk("queued_id", evt_id, 3);
        chk("queued_long", evt_long, 1);
        step();
        chk("queued_end", evt_valid, 0);
        evt_ready = 1'b0;

        pulse(4'b0100, 3);
        step();
        chk("pre_rst_id", evt_id, 2);
        to_tick();
        btn_raw[1] = 1'b1;
        repeat (6) to_tick();
        chk("pre_rst_level", btn_level, 4'b0010);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", evt_valid, 0);
        chk("mid_rst_id", evt_id, 0);
        chk("mid_rst_level", btn_level, 0);
        step(); step();
        rst = 1'b0; cyc = 0;
        repeat (2) to_tick();
        chk("reacq_level2", btn_level, 0);
        to_tick();
        chk("reacq_level3", btn_level, 4'b0010);
        repeat (2) to_tick();
        btn_raw[1] = 1'b0;
        repeat (3) to_tick();
        chk("reacq_valid_early", evt_valid, 0);
        step();
        chk("reacq_valid", evt_valid, 1);
        chk("reacq_id", evt_id, 1);
        chk("reacq_long", evt_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
